// File: rtl/pixel_cfg_serializer.sv
// Serializes configuration words MSB-first onto sdo with a gated copy of the
// divided config clock (one rising edge per bit) and a load strobe per chain.
module pixel_cfg_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             sclk_in,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             cfg_last,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             sdo,
  output logic             sclk_out,
  output logic             load,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT_NEXT, LOAD, LATCH} state_t;

  state_t          state, state_nxt;
  logic            sclk_r, sclk_d, sclk_en;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]   cnt;
  logic            last_q;
  logic            fall, rise, accept;

  assign fall     = sclk_d & ~sclk_r;
  assign rise     = ~sclk_d & sclk_r;
  assign accept   = cfg_valid & cfg_ready;
  // sclk_en only moves right after a fall, while sclk_r is low, so no glitch
  assign sclk_out = sclk_r & sclk_en;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WAIT_NEXT: if (accept) state_nxt = SHIFT;
      SHIFT:           if (fall && cnt == '0) state_nxt = last_q ? LOAD : WAIT_NEXT;
      LOAD:            if (rise) state_nxt = LATCH;
      LATCH:           if (fall) state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE) || (state == WAIT_NEXT);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sclk_r <= 1'b0;
      sclk_d <= 1'b0;
    end else begin
      sclk_r <= sclk_in;
      sclk_d <= sclk_r;
    end
  end

  // Edges seen in the accept cycle are dropped: the accept branch wins.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      cnt     <= '0;
      last_q  <= 1'b0;
      sdo     <= 1'b0;
      sclk_en <= 1'b0;
    end else if (accept) begin
      shreg  <= cfg_data;
      cnt    <= CW'(WIDTH);
      last_q <= cfg_last;
    end else if (state == SHIFT && fall) begin
      if (cnt != '0) begin
        sdo     <= shreg[WIDTH-1];
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        cnt     <= cnt - CW'(1);
        sclk_en <= 1'b1;
      end else begin
        sclk_en <= 1'b0;
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      load <= 1'b0;
      done <= 1'b0;
    end else begin
      if (state == LOAD && rise)       load <= 1'b1;
      else if (state == LATCH && fall) load <= 1'b0;
      done <= (state == LATCH) && fall;
    end
  end

endmodule
